// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared constants and requester encoding for the SDP RAM arbiter.
package sdp_ram_arbiter_pkg;

    localparam int DATA_WIDTH  = 1024;
    localparam int BWREN_WIDTH = 128;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/sdp_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2
    import sdp_ram_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e pri_q;

    // Lone requester always wins; on contention the pointer picks. Grants are
    // held low while reset is asserted.
    always_comb begin
        gnt = 2'b00;
        if (RESET_N) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (pri_q == REQ1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer moves to the loser after every grant and holds on idle cycles.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pri_q <= REQ0;
        end else if (gnt[0]) begin
            pri_q <= REQ1;
        end else if (gnt[1]) begin
            pri_q <= REQ0;
        end
    end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Two-requester arbiter in front of a 1024-bit simple-dual-port RAM.
// Write and read ports are arbitrated independently with zero added latency;
// read data returns one cycle after the grant, tagged with the winner.
module sdp_ram_arbiter
    import sdp_ram_arbiter_pkg::*;
#(
    parameter int ADDRS_WIDTH = 12
) (
    input  logic                     CLK,
    input  logic                     RESET_N,

    input  logic                     r0_wrreq,
    input  logic [ADDRS_WIDTH-1:0]   r0_wraddrs,
    input  logic [DATA_WIDTH-1:0]    r0_wrdata,
    input  logic [BWREN_WIDTH-1:0]   r0_bwren,
    output logic                     r0_wrgnt,
    input  logic                     r0_rdreq,
    input  logic [ADDRS_WIDTH-1:0]   r0_rdaddrs,
    output logic                     r0_rdgnt,
    output logic                     r0_rdvalid,

    input  logic                     r1_wrreq,
    input  logic [ADDRS_WIDTH-1:0]   r1_wraddrs,
    input  logic [DATA_WIDTH-1:0]    r1_wrdata,
    input  logic [BWREN_WIDTH-1:0]   r1_bwren,
    output logic                     r1_wrgnt,
    input  logic                     r1_rdreq,
    input  logic [ADDRS_WIDTH-1:0]   r1_rdaddrs,
    output logic                     r1_rdgnt,
    output logic                     r1_rdvalid,

    output logic [DATA_WIDTH-1:0]    rddata,
    output logic                     rd_collision,

    output logic                     ram_wren,
    output logic [BWREN_WIDTH-1:0]   ram_bwren,
    output logic [ADDRS_WIDTH-1:0]   ram_wraddrs,
    output logic [DATA_WIDTH-1:0]    ram_wrdata,
    output logic                     ram_rden,
    output logic [ADDRS_WIDTH-1:0]   ram_rdaddrs,
    input  logic [DATA_WIDTH-1:0]    ram_rddata
);

    logic [1:0] wr_gnt;
    logic [1:0] rd_gnt;
    req_id_e    rd_win;

    logic       rd_tag_vld;
    req_id_e    rd_tag_id;
    logic       rd_coll_q;

    rr_arb2 u_wr_arb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .req     ({r1_wrreq, r0_wrreq}),
        .gnt     (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .req     ({r1_rdreq, r0_rdreq}),
        .gnt     (rd_gnt)
    );

    assign r0_wrgnt = wr_gnt[0];
    assign r1_wrgnt = wr_gnt[1];
    assign r0_rdgnt = rd_gnt[0];
    assign r1_rdgnt = rd_gnt[1];

    // Write mux: byte enables are forced low when nobody is granted so the
    // RAM never sees a stray partial write.
    always_comb begin
        ram_wren    = |wr_gnt;
        ram_wraddrs = wr_gnt[1] ? r1_wraddrs : r0_wraddrs;
        ram_wrdata  = wr_gnt[1] ? r1_wrdata  : r0_wrdata;
        ram_bwren   = '0;
        if (wr_gnt[0]) begin
            ram_bwren = r0_bwren;
        end else if (wr_gnt[1]) begin
            ram_bwren = r1_bwren;
        end
    end

    // Read mux: the winner's address goes straight to the RAM.
    always_comb begin
        ram_rden    = |rd_gnt;
        rd_win      = rd_gnt[1] ? REQ1 : REQ0;
        ram_rdaddrs = rd_gnt[1] ? r1_rdaddrs : r0_rdaddrs;
    end

    // Read tag: remembers who was granted and whether a same-address write
    // happened alongside, so the returning data can be steered and flagged.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_tag_vld <= 1'b0;
            rd_tag_id  <= REQ0;
            rd_coll_q  <= 1'b0;
        end else begin
            rd_tag_vld <= ram_rden;
            if (ram_rden) begin
                rd_tag_id <= rd_win;
                rd_coll_q <= ram_wren && (ram_wraddrs == ram_rdaddrs);
            end
        end
    end

    // Returning read: RAM output passes through unregistered.
    always_comb begin
        rddata       = ram_rddata;
        r0_rdvalid   = rd_tag_vld && (rd_tag_id == REQ0);
        r1_rdvalid   = rd_tag_vld && (rd_tag_id == REQ1);
        rd_collision = rd_tag_vld && rd_coll_q;
    end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Self-checking bench for sdp_ram_arbiter with a behavioural read-before-write RAM.
module tb_sdp_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 1024;
    localparam int BW = 128;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic          coll;
    } rd_exp_t;

    logic          CLK;
    logic          RESET_N;
    logic          r0_wrreq, r1_wrreq, r0_rdreq, r1_rdreq;
    logic [AW-1:0] r0_wraddrs, r1_wraddrs, r0_rdaddrs, r1_rdaddrs;
    logic [DW-1:0] r0_wrdata, r1_wrdata;
    logic [BW-1:0] r0_bwren, r1_bwren;
    logic          r0_wrgnt, r1_wrgnt, r0_rdgnt, r1_rdgnt;
    logic          r0_rdvalid, r1_rdvalid;
    logic [DW-1:0] rddata;
    logic          rd_collision;
    logic          ram_wren, ram_rden;
    logic [BW-1:0] ram_bwren;
    logic [AW-1:0] ram_wraddrs, ram_rdaddrs;
    logic [DW-1:0] ram_wrdata;
    logic [DW-1:0] ram_rddata = '0;

    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] written = '0;

    rd_exp_t exp_q[$];
    rd_exp_t mon_e;
    int checks = 0;
    int errors = 0;

    sdp_ram_arbiter #(.ADDRS_WIDTH(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .r0_wrreq(r0_wrreq), .r0_wraddrs(r0_wraddrs), .r0_wrdata(r0_wrdata),
        .r0_bwren(r0_bwren), .r0_wrgnt(r0_wrgnt), .r0_rdreq(r0_rdreq),
        .r0_rdaddrs(r0_rdaddrs), .r0_rdgnt(r0_rdgnt), .r0_rdvalid(r0_rdvalid),
        .r1_wrreq(r1_wrreq), .r1_wraddrs(r1_wraddrs), .r1_wrdata(r1_wrdata),
        .r1_bwren(r1_bwren), .r1_wrgnt(r1_wrgnt), .r1_rdreq(r1_rdreq),
        .r1_rdaddrs(r1_rdaddrs), .r1_rdgnt(r1_rdgnt), .r1_rdvalid(r1_rdvalid),
        .rddata(rddata), .rd_collision(rd_collision),
        .ram_wren(ram_wren), .ram_bwren(ram_bwren), .ram_wraddrs(ram_wraddrs),
        .ram_wrdata(ram_wrdata), .ram_rden(ram_rden), .ram_rdaddrs(ram_rdaddrs),
        .ram_rddata(ram_rddata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {BW{b}};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d,
                                            input logic [DW-1:0] new_d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

    function automatic int first_diff_byte(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < BW; i++)
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return 0;
    endfunction

    // RAM model: registered read of the pre-write contents, byte-masked write.
    always @(posedge CLK) begin
        if (ram_rden)
            ram_rddata <= written[ram_rdaddrs] ? mem[ram_rdaddrs] : '0;
        if (ram_wren) begin
            mem[ram_wraddrs]     <= merge(written[ram_wraddrs] ? mem[ram_wraddrs] : '0,
                                          ram_wrdata, ram_bwren);
            written[ram_wraddrs] <= 1'b1;
        end
    end

    // Scoreboard: every returning read is matched against the oldest expectation.
    always @(negedge CLK) begin
        if (r0_rdvalid || r1_rdvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdvalid_unexpected: got r1/r0=%b%b, required none", r1_rdvalid, r0_rdvalid);
            end else begin
                mon_e = exp_q.pop_front();
                if ({r1_rdvalid, r0_rdvalid} !== (mon_e.id ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL rdvalid_id: got r1/r0=%b%b, required id %0d", r1_rdvalid, r0_rdvalid, mon_e.id);
                end
                checks++;
                if (rddata !== mon_e.data) begin
                    errors++;
                    $display("FAIL rddata: byte %0d got %h, required %h", first_diff_byte(rddata, mon_e.data),
                             rddata[first_diff_byte(rddata, mon_e.data)*8 +: 8],
                             mon_e.data[first_diff_byte(rddata, mon_e.data)*8 +: 8]);
                end
                checks++;
                if (rd_collision !== mon_e.coll) begin
                    errors++;
                    $display("FAIL rd_collision: got %b, required %b", rd_collision, mon_e.coll);
                end
            end
        end else if (rd_collision !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rd_collision_idle: got %b, required 0", rd_collision);
        end
    end

    task automatic push_exp(input logic id, input logic [DW-1:0] data, input logic coll);
        rd_exp_t e;
        e.id = id; e.data = data; e.coll = coll;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        r0_wrreq = 1'b0; r1_wrreq = 1'b0; r0_rdreq = 1'b0; r1_rdreq = 1'b0;
        r0_wraddrs = '0; r1_wraddrs = '0; r0_rdaddrs = '0; r1_rdaddrs = '0;
        r0_wrdata = '0; r1_wrdata = '0; r0_bwren = '0; r1_bwren = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        r0_wrreq = 1'b1; r1_wrreq = 1'b1; r0_rdreq = 1'b1; r1_rdreq = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({r1_wrgnt, r0_wrgnt, r1_rdgnt, r0_rdgnt} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grants: got %b, required 0000", {r1_wrgnt, r0_wrgnt, r1_rdgnt, r0_rdgnt});
        end
        checks++;
        if ({ram_wren, ram_rden} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ram_en: got wren/rden=%b, required 00", {ram_wren, ram_rden});
        end
        checks++;
        if ({r1_rdvalid, r0_rdvalid, rd_collision} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rdvalid: got %b, required 000", {r1_rdvalid, r0_rdvalid, rd_collision});
        end
        drive_idle();
        step();
        RESET_N = 1'b1;
    endtask

    task automatic test_wr_round_robin();
        logic [1:0]    exp_g;
        logic [AW-1:0] exp_a;
        r0_wrreq = 1'b1; r0_wraddrs = 12'h100; r0_wrdata = pat(8'h11); r0_bwren = '1;
        r1_wrreq = 1'b1; r1_wraddrs = 12'h200; r1_wrdata = pat(8'h22); r1_bwren = '1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (i % 2 == 0) ? 12'h100 : 12'h200;
            @(negedge CLK);
            checks++;
            if ({r1_wrgnt, r0_wrgnt} !== exp_g) begin
                errors++;
                $display("FAIL wr_rr_gnt[%0d]: got %b, required %b", i, {r1_wrgnt, r0_wrgnt}, exp_g);
            end
            checks++;
            if (ram_wraddrs !== exp_a || ram_wren !== 1'b1) begin
                errors++;
                $display("FAIL wr_rr_addr[%0d]: got %h wren %b, required %h wren 1", i, ram_wraddrs, ram_wren, exp_a);
            end
            step();
        end
        drive_idle();
        r0_bwren = '1; r1_bwren = '1;
        @(negedge CLK);
        checks++;
        if (ram_wren !== 1'b0 || ram_bwren !== '0) begin
            errors++;
            $display("FAIL wr_idle: got wren %b bwren_nonzero %b, required 0 0", ram_wren, |ram_bwren);
        end
        step();
        drive_idle();
    endtask

    task automatic test_read_after_write();
        r0_wrreq = 1'b1; r0_wraddrs = 12'h005; r0_wrdata = pat(8'hA5); r0_bwren = '1;
        @(negedge CLK);
        checks++;
        if (r0_wrgnt !== 1'b1) begin
            errors++;
            $display("FAIL raw_wrgnt: got %b, required 1", r0_wrgnt);
        end
        step();
        drive_idle();
        r1_rdreq = 1'b1; r1_rdaddrs = 12'h005;
        push_exp(1'b1, pat(8'hA5), 1'b0);
        @(negedge CLK);
        checks++;
        if ({r1_rdgnt, r0_rdgnt, ram_rden} !== 3'b101 || ram_rdaddrs !== 12'h005) begin
            errors++;
            $display("FAIL raw_rdgnt: got gnt/rden %b addr %h, required 101 addr 005",
                     {r1_rdgnt, r0_rdgnt, ram_rden}, ram_rdaddrs);
        end
        step();
        drive_idle();
        @(negedge CLK);
        checks++;
        if ({r1_rdvalid, r0_rdvalid} !== 2'b10) begin
            errors++;
            $display("FAIL raw_rdvalid: got r1/r0=%b, required 10", {r1_rdvalid, r0_rdvalid});
        end
        step();
    endtask

    task automatic test_collision();
        r1_wrreq = 1'b1; r1_wraddrs = 12'h010; r1_wrdata = pat(8'h3C); r1_bwren = '1;
        step();
        drive_idle();
        r0_wrreq = 1'b1; r0_wraddrs = 12'h010; r0_wrdata = pat(8'hC3); r0_bwren = '1;
        r1_rdreq = 1'b1; r1_rdaddrs = 12'h010;
        push_exp(1'b1, pat(8'h3C), 1'b1);
        @(negedge CLK);
        checks++;
        if ({r0_wrgnt, r1_rdgnt} !== 2'b11) begin
            errors++;
            $display("FAIL coll_gnt: got wr0/rd1=%b, required 11", {r0_wrgnt, r1_rdgnt});
        end
        step();
        drive_idle();
        @(negedge CLK);
        checks++;
        if (rd_collision !== 1'b1) begin
            errors++;
            $display("FAIL coll_flag: got %b, required 1", rd_collision);
        end
        step();
        r0_rdreq = 1'b1; r0_rdaddrs = 12'h010;
        push_exp(1'b0, pat(8'hC3), 1'b0);
        step();
        drive_idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addr_t [3];
        logic [7:0]    byte_t [3];
        addr_t = '{12'h100, 12'h200, 12'h005};
        byte_t = '{8'h11, 8'h22, 8'hA5};
        r0_rdreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r0_rdaddrs = addr_t[i];
            push_exp(1'b0, pat(byte_t[i]), 1'b0);
            @(negedge CLK);
            checks++;
            if (r0_rdgnt !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: got %b, required 1", i, r0_rdgnt);
            end
            if (i > 0) begin
                checks++;
                if (r0_rdvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_rdvalid[%0d]: got %b, required 1", i, r0_rdvalid);
                end
            end
            step();
        end
        // Pointer now favours r1 after three r0 grants.
        r0_rdreq = 1'b1; r0_rdaddrs = 12'h100;
        r1_rdreq = 1'b1; r1_rdaddrs = 12'h200;
        push_exp(1'b1, pat(8'h22), 1'b0);
        @(negedge CLK);
        checks++;
        if ({r1_rdgnt, r0_rdgnt} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_contend1: got %b, required 10", {r1_rdgnt, r0_rdgnt});
        end
        step();
        push_exp(1'b0, pat(8'h11), 1'b0);
        @(negedge CLK);
        checks++;
        if ({r1_rdgnt, r0_rdgnt} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_contend2: got %b, required 01", {r1_rdgnt, r0_rdgnt});
        end
        step();
        drive_idle();
        step();
    endtask

    task automatic test_byte_enables();
        r0_wrreq = 1'b1; r0_wraddrs = 12'h000; r0_wrdata = '1; r0_bwren = 128'h1;
        step();
        drive_idle();
        r0_rdreq = 1'b1; r0_rdaddrs = 12'h000;
        push_exp(1'b0, {{(DW-8){1'b0}}, 8'hFF}, 1'b0);
        step();
        drive_idle();
        // Contended write where the winner carries no byte enables.
        r1_wrreq = 1'b1; r1_wraddrs = 12'h000; r1_wrdata = '1; r1_bwren = '0;
        r0_wrreq = 1'b1; r0_wraddrs = 12'h020; r0_wrdata = pat(8'h77); r0_bwren = '1;
        @(negedge CLK);
        checks++;
        if ({r1_wrgnt, r0_wrgnt, ram_wren} !== 3'b101 || ram_bwren !== '0) begin
            errors++;
            $display("FAIL be0_gnt: got gnt/wren %b bwren_nonzero %b, required 101 0",
                     {r1_wrgnt, r0_wrgnt, ram_wren}, |ram_bwren);
        end
        step();
        @(negedge CLK);
        checks++;
        if ({r1_wrgnt, r0_wrgnt} !== 2'b01 || ram_wraddrs !== 12'h020) begin
            errors++;
            $display("FAIL be0_turn: got gnt %b addr %h, required 01 addr 020", {r1_wrgnt, r0_wrgnt}, ram_wraddrs);
        end
        step();
        drive_idle();
        r1_rdreq = 1'b1; r1_rdaddrs = 12'h000;
        push_exp(1'b1, {{(DW-8){1'b0}}, 8'hFF}, 1'b0);
        step();
        drive_idle();
        step();
    endtask

    task automatic test_reset_during_read();
        r0_rdreq = 1'b1; r0_rdaddrs = 12'h005;
        r0_wrreq = 1'b1; r0_wraddrs = 12'h030; r0_bwren = '0;
        @(negedge CLK);
        checks++;
        if (r0_rdgnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_gnt: got %b, required 1", r0_rdgnt);
        end
        step();
        RESET_N = 1'b0;
        drive_idle();
        @(negedge CLK);
        checks++;
        if ({r1_rdvalid, r0_rdvalid, rd_collision} !== 3'b000) begin
            errors++;
            $display("FAIL rst_rd_valid: got %b, required 000", {r1_rdvalid, r0_rdvalid, rd_collision});
        end
        step();
        RESET_N = 1'b1;
        @(negedge CLK);
        checks++;
        if ({r1_rdvalid, r0_rdvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_rd_after: got %b, required 00", {r1_rdvalid, r0_rdvalid});
        end
        step();
        r0_rdreq = 1'b1; r0_rdaddrs = 12'h100;
        r1_rdreq = 1'b1; r1_rdaddrs = 12'h200;
        r0_wrreq = 1'b1; r0_wraddrs = 12'h040;
        r1_wrreq = 1'b1; r1_wraddrs = 12'h050;
        push_exp(1'b0, pat(8'h11), 1'b0);
        @(negedge CLK);
        checks++;
        if ({r1_rdgnt, r0_rdgnt, r1_wrgnt, r0_wrgnt} !== 4'b0101) begin
            errors++;
            $display("FAIL rst_pri: got rd/wr gnt %b, required 0101", {r1_rdgnt, r0_rdgnt, r1_wrgnt, r0_wrgnt});
        end
        step();
        drive_idle();
        step();
        step();
    endtask

    initial begin
        RESET_N = 1'b0;
        drive_idle();
        test_reset();
        test_wr_round_robin();
        test_read_after_write();
        test_collision();
        test_back_to_back();
        test_byte_enables();
        test_reset_during_read();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_outstanding: got %0d reads never returned, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdp_ram_arbiter.md
SDP_RAM_ARBITER -- requirements
Module: sdp_ram_arbiter

Interface
REQ-001 Parameter ADDRS_WIDTH, default 12: address width of the shared 1024-bit simple-dual-port RAM.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 rN_wrreq  in  1  (N=0,1) write request from requester N.
REQ-005 rN_wraddrs  in  ADDRS_WIDTH  write address; rN_wrdata  in  1024  write data; rN_bwren  in  128  byte-write enables.
REQ-006 rN_wrgnt  out  1  write granted this cycle; the write is accepted when wrreq and wrgnt are both high.
REQ-007 rN_rdreq  in  1  read request; rN_rdaddrs  in  ADDRS_WIDTH  read address.
REQ-008 rN_rdgnt  out  1  read granted this cycle; rN_rdvalid  out  1  read data valid, one cycle after the grant.
REQ-009 rddata  out  1024  shared read data, qualified only by rN_rdvalid; rd_collision  out  1  the read returned with rdvalid hit a same-cycle write.
REQ-010 RAM side: ram_wren, ram_bwren[127:0], ram_wraddrs, ram_wrdata[1023:0], ram_rden, ram_rdaddrs  out; ram_rddata[1023:0]  in.

Function
REQ-011 Write and read ports SHALL be arbitrated independently; one write and one read may be granted in the same cycle.
REQ-012 Grants SHALL be combinational from the current requests and the registered priority pointer; zero added latency.
REQ-013 Only one requester active on a port: it SHALL be granted every cycle it requests.
REQ-014 Both requesters active on a port: the requester named by that port's pointer (wr_pri / rd_pri, 0 or 1) SHALL be granted.
REQ-015 The pointer SHALL be updated on every grant to the non-granted requester; it SHALL hold on cycles with no grant.
REQ-016 Granted write: ram_wren=1, and ram_wraddrs/ram_wrdata/ram_bwren SHALL be muxed from the winner.
REQ-017 No write grant: ram_wren=0 and ram_bwren=0; the data and address buses are don't-care.
REQ-018 Granted read: ram_rden=1 and ram_rdaddrs SHALL be muxed from the winner.
REQ-019 A registered read tag SHALL record the winner; the next cycle, exactly that requester's rdvalid=1.
REQ-020 rddata SHALL equal ram_rddata unregistered, giving a total read latency of 1 cycle.
REQ-021 rdvalid SHALL be 0 for both requesters when no read was granted the previous cycle; the RAM output may change on write-only cycles and is ignored.
REQ-022 Back-to-back reads SHALL produce back-to-back rdvalid pulses, one per grant, in grant order.
REQ-023 Read and write granted to the same address in one cycle: the read SHALL return the old (pre-write) data.
- In that case rd_collision SHALL be 1 in the cycle its rdvalid is high; otherwise rd_collision is 0.
REQ-024 A write with rN_bwren all zero SHALL still be granted and consume the arbitration turn; memory is unchanged.
REQ-025 Requests are level-sensitive; no request is queued, and a requester not granted SHALL hold its request.

Reset
REQ-026 While RESET_N=0, registered state SHALL be cleared asynchronously.
- wr_pri=0 and rd_pri=0.
- Read tag valid = 0.
- r0_rdvalid = r1_rdvalid = rd_collision = 0.
REQ-027 Combinational grants SHALL be forced to 0 while RESET_N=0, so ram_wren=0 and ram_rden=0.
REQ-028 A read granted in the cycle before reset asserts SHALL NOT produce rdvalid after reset releases.

Structure
REQ-029 A shared package SHALL hold the constants DATA_WIDTH=1024, BWREN_WIDTH=128 and the requester-ID encoding (REQ0=0, REQ1=1).
REQ-030 One sub-module, rr_arb2: a two-way round-robin arbiter with a pointer register, instantiated once for the write port and once for the read port.

Verification
REQ-031 Reset release; r0_wrreq=r1_wrreq=1 for 4 cycles -> wrgnt sequence r0,r1,r0,r1; ram_wraddrs follows the winner.
REQ-032 r1 reads 0x005 after a write of 0xA5 pattern to 0x005 -> r1_rdvalid=1 one cycle later; rddata=0xA5 pattern; r0_rdvalid=0.
REQ-033 Same cycle: write 0x010 with new data and read 0x010 holding old data -> next cycle rddata=old data, rd_collision=1.
REQ-034 Only r0_rdreq held for 3 cycles -> three consecutive r0_rdgnt and r0_rdvalid pulses; rd_pri ends at 1.
REQ-035 Write with bwren=128'h1 to 0x000 holding zeros, data all ones -> readback 1024'hFF (byte 0 only).
REQ-036 RESET_N asserted the cycle after a read grant -> rdvalid stays 0; after release, the first contended grant goes to r0.
